// File: rtl/debug_trace_buffer.sv
// Circular capture buffer for debug-display MMIO writes.
// Holds the last DEPTH words; browse by logical index with registered readback.
module debug_trace_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              freeze,
   input  logic              clear,
   input  logic              addr_up,
   input  logic              addr_dn,
   input  logic              addr_load,
   input  logic [IDX_W-1:0]  addr_in,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic [IDX_W-1:0]  view_idx,
   output logic [IDX_W:0]    count,
   output logic              full,
   output logic              overflow
);

   localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [IDX_W:0]    count_q, count_d;
   logic [IDX_W-1:0]  view_q, view_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dv_q, dv_d;

   logic              wr_acc;
   logic              full_q;
   logic [IDX_W:0]    newest;
   logic [IDX_W:0]    view_inc;
   logic [IDX_W-1:0]  phys;

   assign wr_acc   = wr_en & ~freeze & ~clear;
   assign full_q   = (count_q == DEPTH_C);
   assign newest   = (count_d == '0) ? '0 : count_d - 1'b1;
   assign view_inc = {1'b0, view_q} + 1'b1;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (clear) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (full_q) ovf_d = 1'b1;
         else        count_d = count_q + 1'b1;
      end
   end

   // navigation sees the post-write fill level
   always_comb begin
      view_d = view_q;
      if (clear || count_d == '0) begin
         view_d = '0;
      end else if (addr_load) begin
         view_d = ({1'b0, addr_in} < count_d) ? addr_in : newest[IDX_W-1:0];
      end else if (addr_up && !addr_dn) begin
         view_d = (view_inc >= count_d) ? '0 : view_inc[IDX_W-1:0];
      end else if (addr_dn && !addr_up) begin
         view_d = (view_q == '0) ? newest[IDX_W-1:0] : view_q - 1'b1;
      end
   end

   assign phys = wr_ptr_d - count_d[IDX_W-1:0] + view_d;

   always_comb begin
      dout_d = '0;
      dv_d   = (count_d != '0);
      if (dv_d) begin
         if (wr_acc && phys == wr_ptr_q) dout_d = wr_data;
         else                            dout_d = mem_q[phys];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_acc) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
         view_q   <= '0;
         ovf_q    <= 1'b0;
         dout_q   <= '0;
         dv_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         view_q   <= view_d;
         ovf_q    <= ovf_d;
         dout_q   <= dout_d;
         dv_q     <= dv_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dv_q;
   assign view_idx   = view_q;
   assign count      = count_q;
   assign full       = full_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed plus random checks of debug_trace_buffer
// against a queue-based model of the retained trace.
module tb_debug_trace_buffer;

   localparam int DW = 32;
   localparam int D  = 32;
   localparam int IW = 5;

   logic          clk = 1'b0;
   logic          rst, wr_en, freeze, clear;
   logic          addr_up, addr_dn, addr_load;
   logic [DW-1:0] wr_data;
   logic [IW-1:0] addr_in;
   logic [DW-1:0] dout;
   logic          dout_valid, full, overflow;
   logic [IW-1:0] view_idx;
   logic [IW:0]   count;

   always #5 clk = ~clk;

   debug_trace_buffer #(.DATA_W(DW), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .freeze(freeze), .clear(clear), .addr_up(addr_up),
      .addr_dn(addr_dn), .addr_load(addr_load), .addr_in(addr_in),
      .dout(dout), .dout_valid(dout_valid), .view_idx(view_idx),
      .count(count), .full(full), .overflow(overflow)
   );

   logic [DW-1:0] q[$];
   int            view;
   bit            ovf;
   int            vectors = 0;
   int            errs = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic we,
                      input logic [DW-1:0] wd, input logic frz,
                      input logic clr, input logic up, input logic dn,
                      input logic ld, input logic [IW-1:0] ain);
      int n;
      logic [DW-1:0] exp_d;
      rst = r; wr_en = we; wr_data = wd; freeze = frz; clear = clr;
      addr_up = up; addr_dn = dn; addr_load = ld; addr_in = ain;
      @(posedge clk);
      #1;
      if (r || clr) begin
         q.delete();
         view = 0;
         ovf = 0;
      end else begin
         if (we && !frz) begin
            if (q.size() == D) begin
               void'(q.pop_front());
               ovf = 1;
            end
            q.push_back(wd);
         end
         n = q.size();
         if (n == 0) view = 0;
         else if (ld) view = (int'(ain) < n) ? int'(ain) : n - 1;
         else if (up && !dn) view = (view + 1 >= n) ? 0 : view + 1;
         else if (dn && !up) view = (view == 0) ? n - 1 : view - 1;
      end
      n = q.size();
      exp_d = (n == 0) ? '0 : q[view];
      vectors++;
      chk("count", 64'(count), 64'(n));
      chk("view_idx", 64'(view_idx), 64'(view));
      chk("dout", 64'(dout), 64'(exp_d));
      chk("dout_valid", 64'(dout_valid), 64'(n != 0));
      chk("full", 64'(full), 64'(n == D));
      chk("overflow", 64'(overflow), 64'(ovf));
   endtask

   task automatic idle();
      cyc(0, 0, '0, 0, 0, 0, 0, 0, '0);
   endtask
   task automatic wr(input logic [DW-1:0] d);
      cyc(0, 1, d, 0, 0, 0, 0, 0, '0);
   endtask
   task automatic nav(input logic up, input logic dn);
      cyc(0, 0, '0, 0, 0, up, dn, 0, '0);
   endtask
   task automatic load(input logic [IW-1:0] a);
      cyc(0, 0, '0, 0, 0, 0, 0, 1, a);
   endtask
   task automatic reset();
      cyc(1, 0, '0, 0, 0, 0, 0, 0, '0);
   endtask

   initial begin
      q.delete();
      view = 0;
      ovf = 0;
      #1;
      reset();
      chk("rst_dout", 64'(dout), 64'h0);

      wr(32'hA0); wr(32'hA1); wr(32'hA2);
      chk("t1_dout", 64'(dout), 64'hA0);
      nav(1, 0); chk("t2_up1", 64'(dout), 64'hA1);
      nav(1, 0); chk("t2_up2", 64'(dout), 64'hA2);
      nav(1, 0); chk("t2_wrap", 64'(dout), 64'hA0);
      nav(0, 1); chk("t2_dnwrap", 64'(dout), 64'hA2);
      nav(1, 1); chk("t2_both", 64'(view_idx), 64'd2);
      load(5'd7); chk("t2_ldclamp", 64'(view_idx), 64'd2);

      reset();
      for (int i = 0; i < 34; i++) wr(DW'(i));
      load(5'd0); chk("t3_idx0", 64'(dout), 64'd2);
      load(5'd31); chk("t3_idx31", 64'(dout), 64'd33);
      wr(32'd34); chk("t3_shift", 64'(dout), 64'd34);

      for (int i = 0; i < 3; i++) cyc(0, 1, 32'hFF, 1, 0, 0, 0, 0, '0);
      cyc(0, 1, 32'hFF, 1, 0, 0, 1, 0, '0);
      wr(32'hBEEF);
      load(5'd31); chk("t4_capt", 64'(dout), 64'hBEEF);

      cyc(0, 1, 32'h55, 0, 1, 1, 0, 0, '0);
      chk("t5_dv", 64'(dout_valid), 64'd0);
      wr(32'h77); chk("t5_first", 64'(dout), 64'h77);

      reset();
      for (int i = 0; i < 5; i++) wr(32'hC0 + DW'(i));
      load(5'd3); chk("t6_pre", 64'(dout), 64'hC3);
      cyc(1, 1, 32'hDD, 0, 0, 1, 0, 0, '0);
      chk("t6_cnt", 64'(count), 64'd0);
      wr(32'hE0); chk("t6_first", 64'(dout), 64'hE0);

      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 499) == 0,
             $urandom_range(0, 2) != 0,
             DW'($urandom),
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 199) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0,
             IW'($urandom));
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
